// File: rtl/ysyx_22040632_trap_ctrl.sv
// Machine-mode trap sequencer: CLINT-style mtime/mtimecmp timer plus a
// three-state IDLE/TRAP/REDIRECT controller driving CSR strobes and fetch redirect.
module ysyx_22040632_trap_ctrl (
    input  logic        clk,
    input  logic        rrst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ecall,
    input  logic        wb_mret,
    input  logic        mstatus_mie_bit,
    input  logic        mie_mtie_bit,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mmio_wen,
    input  logic [31:0] mmio_addr,
    input  logic [63:0] mmio_wdata,
    output logic [63:0] mmio_rdata,
    output logic        wen_ecall2csr,
    output logic [63:0] NO2csr,
    output logic [31:0] pc2csr,
    output logic        wen_mstatus_ecall2csr,
    output logic        wen_mstatus_mret2csr,
    output logic        wb_stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [31:0] MTIME_ADDR    = 32'h0200_BFF8;
    localparam logic [31:0] MTIMECMP_ADDR = 32'h0200_4000;
    localparam logic [63:0] CAUSE_TIMER   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL   = 64'd11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRAP     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_TIMER = 2'd0,
        K_ECALL = 2'd1,
        K_MRET  = 2'd2
    } kind_t;

    state_t      state_r;
    kind_t       kind_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        timer_pending_s;
    logic        irq_take_s;
    logic        mtime_hit_s;
    logic        mtimecmp_hit_s;

    assign mtime_hit_s     = (mmio_addr == MTIME_ADDR);
    assign mtimecmp_hit_s  = (mmio_addr == MTIMECMP_ADDR);
    assign timer_pending_s = (mtime_r >= mtimecmp_r);
    assign irq_take_s      = timer_pending_s & mstatus_mie_bit & mie_mtie_bit;

    // MMIO read mux over the live timer registers
    always_comb begin
        mmio_rdata = 64'd0;
        if (mtime_hit_s) begin
            mmio_rdata = mtime_r;
        end else if (mtimecmp_hit_s) begin
            mmio_rdata = mtimecmp_r;
        end else begin
            mmio_rdata = 64'd0;
        end
    end

    // Free-running mtime (a write wins over the increment) and mtimecmp
    always_ff @(posedge clk) begin
        if (rrst) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (mmio_wen && mtime_hit_s) begin
                mtime_r <= mmio_wdata;
            end else begin
                mtime_r <= mtime_r + 64'd1;
            end
            if (mmio_wen && mtimecmp_hit_s) begin
                mtimecmp_r <= mmio_wdata;
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end
        end
    end

    // Trap sequencer; all outputs are registered and reflect the current state
    always_ff @(posedge clk) begin
        if (rrst) begin
            state_r               <= S_IDLE;
            kind_r                <= K_ECALL;
            wen_ecall2csr         <= 1'b0;
            wen_mstatus_ecall2csr <= 1'b0;
            wen_mstatus_mret2csr  <= 1'b0;
            NO2csr                <= 64'd0;
            pc2csr                <= 32'd0;
            flush                 <= 1'b0;
            wb_stall              <= 1'b0;
            redirect_valid        <= 1'b0;
            redirect_pc           <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (wb_valid && (irq_take_s || wb_ecall || wb_mret)) begin
                        state_r  <= S_TRAP;
                        flush    <= 1'b1;
                        wb_stall <= 1'b1;
                        if (irq_take_s) begin
                            kind_r                <= K_TIMER;
                            wen_ecall2csr         <= 1'b1;
                            wen_mstatus_ecall2csr <= 1'b1;
                            pc2csr                <= wb_pc;
                            NO2csr                <= CAUSE_TIMER;
                        end else if (wb_ecall) begin
                            // ecall also wins over a simultaneous mret
                            kind_r                <= K_ECALL;
                            wen_ecall2csr         <= 1'b1;
                            wen_mstatus_ecall2csr <= 1'b1;
                            pc2csr                <= wb_pc;
                            NO2csr                <= CAUSE_ECALL;
                        end else begin
                            kind_r               <= K_MRET;
                            wen_mstatus_mret2csr <= 1'b1;
                            pc2csr               <= 32'd0;
                            NO2csr               <= 64'd0;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_TRAP: begin
                    state_r               <= S_REDIRECT;
                    wen_ecall2csr         <= 1'b0;
                    wen_mstatus_ecall2csr <= 1'b0;
                    wen_mstatus_mret2csr  <= 1'b0;
                    NO2csr                <= 64'd0;
                    pc2csr                <= 32'd0;
                    flush                 <= 1'b0;
                    wb_stall              <= 1'b1;
                    redirect_valid        <= 1'b1;
                    redirect_pc           <= (kind_r == K_MRET) ? mepc : mtvec;
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state_r        <= S_IDLE;
                        redirect_valid <= 1'b0;
                        wb_stall       <= 1'b0;
                    end else begin
                        state_r <= S_REDIRECT;
                    end
                end
                default: begin
                    state_r               <= S_IDLE;
                    wen_ecall2csr         <= 1'b0;
                    wen_mstatus_ecall2csr <= 1'b0;
                    wen_mstatus_mret2csr  <= 1'b0;
                    NO2csr                <= 64'd0;
                    pc2csr                <= 32'd0;
                    flush                 <= 1'b0;
                    wb_stall              <= 1'b0;
                    redirect_valid        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_trap_ctrl.sv
// Directed bench for ysyx_22040632_trap_ctrl: ecall, mret, timer interrupt,
// priority, MMIO timer access and reset abort, with hand-computed expectations.
module tb_ysyx_22040632_trap_ctrl;

    localparam logic [31:0] A_MTIME    = 32'h0200_BFF8;
    localparam logic [31:0] A_MTIMECMP = 32'h0200_4000;
    localparam logic [63:0] C_TIMER    = 64'h8000_0000_0000_0007;
    localparam logic [63:0] ONES       = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rrst;
    logic        wb_valid, wb_ecall, wb_mret;
    logic [31:0] wb_pc;
    logic        mstatus_mie_bit, mie_mtie_bit;
    logic [31:0] mtvec, mepc;
    logic        mmio_wen;
    logic [31:0] mmio_addr;
    logic [63:0] mmio_wdata;
    logic [63:0] mmio_rdata;
    logic        wen_ecall2csr;
    logic [63:0] NO2csr;
    logic [31:0] pc2csr;
    logic        wen_mstatus_ecall2csr, wen_mstatus_mret2csr;
    logic        wb_stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int passed = 0;
    int total  = 0;
    int hit_at;

    always #5 clk = ~clk;

    ysyx_22040632_trap_ctrl dut (
        .clk(clk), .rrst(rrst),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ecall(wb_ecall), .wb_mret(wb_mret),
        .mstatus_mie_bit(mstatus_mie_bit), .mie_mtie_bit(mie_mtie_bit),
        .mtvec(mtvec), .mepc(mepc),
        .mmio_wen(mmio_wen), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata),
        .wen_ecall2csr(wen_ecall2csr), .NO2csr(NO2csr), .pc2csr(pc2csr),
        .wen_mstatus_ecall2csr(wen_mstatus_ecall2csr),
        .wen_mstatus_mret2csr(wen_mstatus_mret2csr),
        .wb_stall(wb_stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rrst = 1'b1; wb_valid = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0; wb_pc = 32'd0;
        mstatus_mie_bit = 1'b0; mie_mtie_bit = 1'b0;
        mtvec = 32'h8000_0400; mepc = 32'h8000_0200;
        mmio_wen = 1'b0; mmio_addr = A_MTIME; mmio_wdata = 64'd0; redirect_ready = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_mtime", mmio_rdata, 64'd0);
        chk("rst_outs", {wen_ecall2csr, wen_mstatus_ecall2csr, wen_mstatus_mret2csr,
                         flush, wb_stall, redirect_valid}, 64'd0);
        chk("rst_rpc", {32'd0, redirect_pc}, 64'd0);
        mmio_addr = A_MTIMECMP; #1;
        chk("rst_mtimecmp", mmio_rdata, ONES);
        mmio_addr = 32'h0200_0000; #1;
        chk("unmapped_rd", mmio_rdata, 64'd0);
        mmio_addr = A_MTIME;
        rrst = 1'b0;
        tick();
        chk("mtime_inc", mmio_rdata, 64'd1);

        // ECALL
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_0100;
        tick();
        chk("ec_wen", {wen_ecall2csr, wen_mstatus_ecall2csr, wen_mstatus_mret2csr}, 64'd6);
        chk("ec_no", NO2csr, 64'd11);
        chk("ec_pc", {32'd0, pc2csr}, 64'h8000_0100);
        chk("ec_flush_stall", {flush, wb_stall, redirect_valid}, 64'd6);
        tick();  // ecall still asserted in TRAP: must be ignored
        chk("ec_redir", {redirect_valid, flush, wen_ecall2csr, wb_stall}, 64'd9);
        chk("ec_rpc", {32'd0, redirect_pc}, 64'h8000_0400);
        chk("ec_zero_no_pc", {NO2csr[31:0], pc2csr}, 64'd0);
        tick();  // still REDIRECT, ecall held, ready low
        chk("ec_hold", {redirect_valid, wen_ecall2csr, flush}, 64'd4);
        wb_valid = 1'b0; wb_ecall = 1'b0; redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("ec_done", {redirect_valid, wb_stall}, 64'd0);

        // MRET with ready low three cycles
        wb_valid = 1'b1; wb_mret = 1'b1; wb_pc = 32'h8000_0300;
        tick();
        wb_valid = 1'b0; wb_mret = 1'b0;
        chk("mr_wen", {wen_ecall2csr, wen_mstatus_ecall2csr, wen_mstatus_mret2csr, flush}, 64'd3);
        chk("mr_no_pc", {NO2csr[31:0], pc2csr}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_wait", {redirect_valid, wb_stall, wen_mstatus_mret2csr}, 64'd6);
            chk("mr_rpc", {32'd0, redirect_pc}, 64'h8000_0200);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("mr_done", {redirect_valid, wb_stall}, 64'd0);

        // ecall and mret together behave as ecall
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_mret = 1'b1; wb_pc = 32'h8000_0500;
        tick();
        wb_valid = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0;
        chk("both_wen", {wen_ecall2csr, wen_mstatus_mret2csr}, 64'd2);
        chk("both_no", NO2csr, 64'd11);
        tick();
        chk("both_rpc", {32'd0, redirect_pc}, 64'h8000_0400);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // events without wb_valid are ignored
        wb_ecall = 1'b1; wb_mret = 1'b1;
        tick(); tick();
        chk("novalid", {flush, wb_stall, wen_ecall2csr, wen_mstatus_mret2csr}, 64'd0);
        wb_ecall = 1'b0; wb_mret = 1'b0;

        // timer: mtimecmp=20, mtime=0, MIE=0 -> no trap
        mmio_wen = 1'b1; mmio_addr = A_MTIMECMP; mmio_wdata = 64'd20;
        tick();
        mmio_addr = A_MTIME; mmio_wdata = 64'd0;
        mie_mtie_bit = 1'b1;
        tick();
        mmio_wen = 1'b0; wb_valid = 1'b1; wb_pc = 32'h8000_0600;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("tmr_mie0", {flush, wen_ecall2csr}, 64'd0);
        end
        // MIE=1: first accept when mtime (before the edge) reaches 20
        wb_valid = 1'b0; mstatus_mie_bit = 1'b1;
        mmio_wen = 1'b1; mmio_wdata = 64'd0;
        tick();
        mmio_wen = 1'b0; wb_valid = 1'b1;
        hit_at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (flush) begin
                hit_at = i;
                break;
            end
        end
        wb_valid = 1'b0;
        chk("tmr_edge", hit_at, 64'd21);
        chk("tmr_mtime", mmio_rdata, 64'd21);
        chk("tmr_no", NO2csr, C_TIMER);
        chk("tmr_pc", {32'd0, pc2csr}, 64'h8000_0600);
        chk("tmr_wen", {wen_ecall2csr, wen_mstatus_ecall2csr}, 64'd3);
        tick();
        chk("tmr_rpc", {32'd0, redirect_pc}, 64'h8000_0400);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // timer pending and ecall together: interrupt wins, single TRAP cycle
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_0700;
        tick();
        wb_valid = 1'b0; wb_ecall = 1'b0;
        chk("prio_no", NO2csr, C_TIMER);
        chk("prio_wen", {wen_ecall2csr, flush}, 64'd3);
        tick();
        chk("prio_single", {wen_ecall2csr, flush, redirect_valid}, 64'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        mstatus_mie_bit = 1'b0;

        // mtime wrap
        mmio_wen = 1'b1; mmio_addr = A_MTIME; mmio_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        mmio_wen = 1'b0;
        chk("wrap_fe", mmio_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        chk("wrap_ff", mmio_rdata, ONES);
        tick();
        chk("wrap_0", mmio_rdata, 64'd0);
        mmio_wen = 1'b1; mmio_addr = 32'h0200_0000; mmio_wdata = 64'd5;
        tick();
        mmio_wen = 1'b0; mmio_addr = A_MTIME; #1;
        chk("unmapped_wr", mmio_rdata, 64'd1);
        mmio_addr = A_MTIMECMP; #1;
        chk("cmp_keep", mmio_rdata, 64'd20);
        mmio_addr = A_MTIME;

        // reset during REDIRECT
        wb_valid = 1'b1; wb_ecall = 1'b1;
        tick();
        wb_valid = 1'b0; wb_ecall = 1'b0;
        tick();
        chk("pre_rst_redir", {31'd0, redirect_valid}, 64'd1);
        rrst = 1'b1; mmio_wen = 1'b1; mmio_wdata = 64'd99;
        tick();
        mmio_wen = 1'b0;
        chk("rst_redir", {redirect_valid, wb_stall, flush}, 64'd0);
        chk("rst_rpc2", {32'd0, redirect_pc}, 64'd0);
        chk("rst_mtime2", mmio_rdata, 64'd0);
        mmio_addr = A_MTIMECMP; #1;
        chk("rst_cmp2", mmio_rdata, ONES);
        mmio_addr = A_MTIME;
        rrst = 1'b0;

        // reset during TRAP aborts without further strobes
        wb_valid = 1'b1; wb_ecall = 1'b1;
        tick();
        chk("trap2", {31'd0, wen_ecall2csr}, 64'd1);
        rrst = 1'b1;
        tick();
        wb_valid = 1'b0; wb_ecall = 1'b0;
        chk("rst_trap", {wen_ecall2csr, flush, wb_stall}, 64'd0);
        rrst = 1'b0;
        tick();
        chk("rst_trap_after", {redirect_valid, wb_stall, wen_ecall2csr}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_trap_ctrl.md
YSYX_22040632_TRAP_CTRL -- requirements
Module: ysyx_22040632_trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rrst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: wb_valid  in  1  writeback holds a retiring instruction; wb_pc  in  32  its PC; wb_ecall  in  1  it is ECALL; wb_mret  in  1  it is MRET.
REQ-004 SHALL have ports: mstatus_mie_bit  in  1; mie_mtie_bit  in  1; mtvec  in  32; mepc  in  32  (all from CSR file).
REQ-005 SHALL have ports: mmio_wen  in  1; mmio_addr  in  32; mmio_wdata  in  64; mmio_rdata  out  64  (combinational read of mmio_addr).
REQ-006 SHALL have ports to CSR file: wen_ecall2csr  out  1; NO2csr  out  64; pc2csr  out  32; wen_mstatus_ecall2csr  out  1; wen_mstatus_mret2csr  out  1.
REQ-007 SHALL have ports: wb_stall  out  1  hold writeback; flush  out  1  kill younger pipeline stages; redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  fetch accepts redirect.

Function
REQ-008 SHALL keep 64-bit mtime (MMIO 0x0200_BFF8), +1 every cycle, wrapping 2^64-1 -> 0.
REQ-009 SHALL keep 64-bit mtimecmp (MMIO 0x0200_4000).
REQ-010 MMIO write to either address SHALL replace the full 64 bits next edge; mtime write overrides that cycle's increment; other addresses ignored.
REQ-011 mmio_rdata SHALL return mtime or mtimecmp for matching address, else 0.
REQ-012 timer_pending SHALL be (mtime >= mtimecmp), unsigned 64-bit compare on registered values.
REQ-013 FSM states: IDLE, TRAP, REDIRECT.
REQ-014 In IDLE with wb_valid=1, event priority: (1) timer interrupt if timer_pending & mstatus_mie_bit & mie_mtie_bit; (2) wb_ecall; (3) wb_mret; none -> stay IDLE.
REQ-015 On event, SHALL latch kind, wb_pc and cause, go to TRAP next cycle.
REQ-016 Causes: interrupt NO = 64'h8000_0000_0000_0007; ecall NO = 64'd11; mret no cause.
REQ-017 TRAP lasts exactly one cycle: interrupt/ecall -> wen_ecall2csr=1, wen_mstatus_ecall2csr=1, pc2csr=latched pc, NO2csr=latched cause; mret -> wen_mstatus_mret2csr=1 only.
REQ-018 flush SHALL be 1 exactly in TRAP; wb_stall SHALL be 1 in TRAP and REDIRECT.
REQ-019 Entering REDIRECT, redirect_pc SHALL latch mtvec (interrupt/ecall) or mepc (mret), sampled in TRAP cycle.
REQ-020 In REDIRECT, redirect_valid=1, redirect_pc stable until redirect_ready=1; that cycle -> IDLE.
REQ-021 IDLE SHALL not accept a new event on the cycle redirect completes (returns IDLE next cycle); no back-to-back accept.
REQ-022 wb_ecall and wb_mret both 1 SHALL be treated as ecall.
REQ-023 Events with wb_valid=0, or outside IDLE, SHALL be ignored; mtime continues counting in all states.
REQ-024 All CSR strobes SHALL be 0 outside TRAP; NO2csr and pc2csr SHALL be 0 when strobes are 0.

Reset
REQ-025 rrst=1 at an edge SHALL force IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, all outputs 0, redirect_pc=0.
REQ-026 Reset in TRAP or REDIRECT SHALL abort the trap without further strobes; reset beats every event and MMIO write.

Verification
REQ-027 ECALL at wb_pc=0x8000_0100, mtvec=0x8000_0400 -> next cycle wen_ecall2csr=1, NO2csr=11, pc2csr=0x8000_0100, flush=1; following cycle redirect_valid=1, redirect_pc=0x8000_0400.
REQ-028 mtimecmp=20, MIE=MTIE=1, wb_valid held with no ecall -> first accept when mtime>=20, NO2csr=0x8000_0000_0000_0007; with MIE=0 no trap.
REQ-029 Timer pending + wb_ecall same cycle -> interrupt cause taken, single TRAP cycle, no ecall trap.
REQ-030 MRET with mepc=0x8000_0200, redirect_ready low 3 cycles -> wen_mstatus_mret2csr=1 one cycle, redirect_valid held 3 cycles at 0x8000_0200, IDLE after ready.
REQ-031 MMIO write mtime=64'hFFFF_FFFF_FFFF_FFFE -> reads ...FFFF next cycle, 0 after.
REQ-032 rrst=1 during REDIRECT -> next cycle redirect_valid=0, wb_stall=0, mtime=0, mtimecmp all ones.
